dmem_arbiter: RTL and testbench

Arbitrates the single-port 64×32 data memory between the pipeline's MEM stage and an external DMA/debug master. CPU has default priority. The external port is guaranteed a grant after a bounded number of contested cycles. The block raises a stall to the pipeline whenever a CPU access is not granted in the current cycle.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter_starve_ctr.sv | 41 ++++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Owner encoding is what the arbiter registers to route completions in the next cycle.
package dmem_pkg;

  localparam int ADDR_W_DEF       = 6;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int CPU_ADDR_W       = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  // A limit of zero still needs a one-bit counter.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU MEM-stage, external master and memory-side signals of the arbiter.
// slave = arbiter view, master = surrounding pipeline/DMA/memory view.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic                  cpu_req;
  logic                  cpu_we;
  logic [CPU_ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic                  cpu_stall;
  logic                  cpu_rvalid;
  logic [DATA_W-1:0]     cpu_rdata;

  logic                  ext_req;
  logic                  ext_we;
  logic [ADDR_W-1:0]     ext_addr;
  logic [DATA_W-1:0]     ext_wdata;
  logic                  ext_ack;
  logic [DATA_W-1:0]     ext_rdata;

  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_ack, ext_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_ack, ext_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating count of contested cycles the external port has lost.
// hold has precedence over clr, which has precedence over inc.
module starve_ctr
  import dmem_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clock,
  input  logic resetn,
  input  logic inc,
  input  logic clr,
  input  logic hold,
  output logic sat
);

  localparam int W = cnt_width(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (hold) begin
      cnt_d = cnt_q;
    end else if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU by default, external port forced after STARVE_LIMIT losses.
// Grant and stall are same-cycle combinational; read data and ext_ack return one cycle later.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clock,
  input  logic          resetn,
  dmem_arbiter_if.slave bus
);

  owner_e            owner;
  owner_e            last_owner_q, last_owner_d;
  logic              last_we_q, last_we_d;
  logic              ext_pend_q, ext_pend_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  logic              ext_elig;
  logic              ext_win;
  logic              cpu_win;
  logic              ext_ack_w;
  logic              starve_sat;
  logic              starve_inc;
  logic              starve_clr;
  logic [ADDR_W-1:0] cpu_word;
  logic              unused_cpu_addr;

  assign cpu_word        = bus.cpu_addr[ADDR_W+1:2];
  assign unused_cpu_addr = ^{bus.cpu_addr[CPU_ADDR_W-1:ADDR_W+2], bus.cpu_addr[1:0]};

  // No grants while reset is asserted, so a held request cannot write during reset.
  always_comb begin
    ext_elig = bus.ext_req && !ext_pend_q;
    ext_win  = 1'b0;
    cpu_win  = 1'b0;
    owner    = OWN_NONE;
    if (resetn) begin
      if (ext_elig && (!bus.cpu_req || starve_sat)) begin
        ext_win = 1'b1;
        owner   = OWN_EXT;
      end else if (bus.cpu_req) begin
        cpu_win = 1'b1;
        owner   = OWN_CPU;
      end
    end
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = cpu_word;
    bus.mem_wdata = bus.cpu_wdata;
    case (owner)
      OWN_CPU: begin
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = cpu_word;
        bus.mem_wdata = bus.cpu_wdata;
      end
      OWN_EXT: begin
        bus.mem_we    = bus.ext_we;
        bus.mem_addr  = bus.ext_addr;
        bus.mem_wdata = bus.ext_wdata;
      end
      default: begin
        bus.mem_we = 1'b0;
      end
    endcase
  end

  assign bus.cpu_stall = bus.cpu_req && (owner != OWN_CPU);

  // The ack cycle is exactly the cycle after an external grant, so ext_pend_q doubles as hold.
  assign starve_inc = bus.ext_req && ext_elig && cpu_win;
  assign starve_clr = ext_win || !bus.ext_req;

  starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clock  (clock),
    .resetn (resetn),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .hold   (ext_pend_q),
    .sat    (starve_sat)
  );

  assign ext_ack_w = (last_owner_q == OWN_EXT);

  always_comb begin
    last_owner_d = owner;
    last_we_d    = bus.mem_we;
    ext_pend_d   = ext_win;
    ext_rdata_d  = ext_rdata_q;
    if (ext_ack_w) begin
      ext_rdata_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_owner_q <= OWN_NONE;
      last_we_q    <= 1'b0;
      ext_pend_q   <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      last_we_q    <= last_we_d;
      ext_pend_q   <= ext_pend_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  // Read data is passed straight through in the ack cycle and held afterwards.
  assign bus.ext_ack    = ext_ack_w;
  assign bus.ext_rdata  = ext_ack_w ? bus.mem_rdata : ext_rdata_q;
  assign bus.cpu_rvalid = (last_owner_q == OWN_CPU) && !last_we_q;
  assign bus.cpu_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter with a cycle-level reference model and a 64x32 memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // Physical memory: read data appears the cycle after the address.
  logic [31:0] phys [64];
  always @(posedge clock) begin
    if (bus.mem_we) phys[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= phys[bus.mem_addr];
  end

  // Reference model state, expressed in cycle numbers and loss counts.
  int          cyc;
  int          last_ext_gnt;
  int          losses;
  int          prev_own;
  bit          prev_we;
  logic [31:0] prev_data;
  logic [31:0] ref_mem [64];
  logic [31:0] ext_hold;
  bit          ext_hold_known;

  bit          exp_stall, exp_we, exp_ack, exp_rvalid;
  int          exp_own;
  logic [5:0]  exp_addr;
  logic [31:0] exp_wd, exp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_reset();
    losses         = 0;
    last_ext_gnt   = -100;
    prev_own       = 0;
    prev_we        = 1'b0;
    prev_data      = '0;
    ext_hold       = '0;
    ext_hold_known = 1'b1;
    exp_ack        = 1'b0;
    exp_rvalid     = 1'b0;
    exp_we         = 1'b0;
    exp_stall      = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    resetn = 1'b0;
    cyc++;
    model_reset();
    @(negedge clock);
  endtask

  // One clock cycle: drive inputs after the edge, predict, and stop at the falling edge.
  task automatic step(input bit creq, input bit cwe, input logic [31:0] caddr,
                      input logic [31:0] cwd, input bit ereq, input bit ewe,
                      input logic [5:0] eaddr, input logic [31:0] ewd);
    bit elig;
    @(posedge clock);
    #1;
    cyc++;
    resetn        = 1'b1;
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.ext_req   = ereq;
    bus.ext_we    = ewe;
    bus.ext_addr  = eaddr;
    bus.ext_wdata = ewd;

    exp_ack    = (prev_own == 2);
    exp_rvalid = (prev_own == 1) && !prev_we;
    exp_rdata  = prev_data;
    if (exp_ack) begin
      ext_hold_known = !prev_we;
      if (!prev_we) ext_hold = prev_data;
    end

    elig    = ereq && (cyc != last_ext_gnt + 1);
    exp_own = 0;
    if (elig && (!creq || losses >= LIMIT)) exp_own = 2;
    else if (creq) exp_own = 1;
    exp_stall = creq && (exp_own != 1);

    exp_we   = 1'b0;
    exp_addr = caddr[7:2];
    exp_wd   = cwd;
    if (exp_own == 1) begin
      exp_we = cwe;
    end else if (exp_own == 2) begin
      exp_we   = ewe;
      exp_addr = eaddr;
      exp_wd   = ewd;
    end

    if (!ereq || exp_own == 2) losses = 0;
    else if (elig && exp_own == 1) losses = (losses + 1 > LIMIT) ? LIMIT : losses + 1;

    prev_own  = exp_own;
    prev_we   = exp_we;
    prev_data = ref_mem[exp_addr];
    if (exp_own != 0 && exp_we) ref_mem[exp_addr] = exp_wd;
    if (exp_own == 2) last_ext_gnt = cyc;
    @(negedge clock);
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 32'h0, 0, 0, 6'd0, 32'h0);
  endtask

  task automatic test_reset();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = 0; bus.ext_wdata = 0;
    do_reset();
    do_reset();
    n_cmp++; if (bus.ext_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ext_ack: got %b want 0", bus.ext_ack); end
    n_cmp++; if (bus.cpu_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_rvalid: got %b want 0", bus.cpu_rvalid); end
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_stall: got %b want 0", bus.cpu_stall); end
    n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    n_cmp++; if (bus.ext_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_ext_rdata: got %h want 0", bus.ext_rdata); end
    step(1, 1, 32'h14, 32'hDEADBEEF, 0, 0, 6'd0, 32'h0);
    n_cmp++; if (bus.mem_addr !== 6'd5) begin n_bad++; $display("FAIL first_store_addr: got %0d want 5", bus.mem_addr); end
    n_cmp++; if (bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL first_store_we: got %b want 1", bus.mem_we); end
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL first_store_stall: got %b want 0", bus.cpu_stall); end
    n_cmp++; if (bus.mem_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL first_store_wdata: got %h want deadbeef", bus.mem_wdata); end
    idle();
    n_cmp++; if (bus.cpu_rvalid !== 1'b0) begin n_bad++; $display("FAIL store_no_rvalid: got %b want 0", bus.cpu_rvalid); end
  endtask

  task automatic test_ext_read();
    step(1, 1, 32'h24, 32'h12345678, 0, 0, 6'd0, 32'h0);
    idle();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'h0, 32'h0, 1, 0, 6'd9, 32'h0);
      n_cmp++; if (bus.ext_ack !== ((i == 1) || (i == 3))) begin n_bad++; $display("FAIL ext_read_ack[%0d]: got %b want %b", i, bus.ext_ack, (i == 1) || (i == 3)); end
      n_cmp++; if (bus.mem_addr !== exp_addr) begin n_bad++; $display("FAIL ext_read_addr[%0d]: got %0d want %0d", i, bus.mem_addr, exp_addr); end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL ext_read_we[%0d]: got %b want 0", i, bus.mem_we); end
      if (i == 1 || i == 3) begin
        n_cmp++; if (bus.ext_rdata !== 32'h12345678) begin n_bad++; $display("FAIL ext_read_data[%0d]: got %h want 12345678", i, bus.ext_rdata); end
      end
    end
    idle();
  endtask

  task automatic test_contention();
    idle();
    for (int i = 0; i < 18; i++) begin
      step(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 1, 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 63)), $urandom);
      n_cmp++; if (bus.cpu_stall !== (i % 6 == 4)) begin n_bad++; $display("FAIL contention_stall[%0d]: got %b want %b", i, bus.cpu_stall, i % 6 == 4); end
      n_cmp++; if (bus.ext_ack !== (i % 6 == 5)) begin n_bad++; $display("FAIL contention_ack[%0d]: got %b want %b", i, bus.ext_ack, i % 6 == 5); end
      n_cmp++; if (bus.mem_we !== exp_we || bus.mem_addr !== exp_addr) begin n_bad++; $display("FAIL contention_mem[%0d]: got we=%b addr=%0d want we=%b addr=%0d", i, bus.mem_we, bus.mem_addr, exp_we, exp_addr); end
      n_cmp++; if (bus.cpu_rvalid !== exp_rvalid) begin n_bad++; $display("FAIL contention_rvalid[%0d]: got %b want %b", i, bus.cpu_rvalid, exp_rvalid); end
      if (exp_rvalid) begin
        n_cmp++; if (bus.cpu_rdata !== exp_rdata) begin n_bad++; $display("FAIL contention_rdata[%0d]: got %h want %h", i, bus.cpu_rdata, exp_rdata); end
      end
    end
    idle();
    idle();
  endtask

  task automatic test_collision();
    idle();
    step(1, 1, 32'h0C, 32'hAAAA0000, 1, 1, 6'd3, 32'h0000BBBB);
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL coll_cpu_stall: got %b want 0", bus.cpu_stall); end
    n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd3 || bus.mem_wdata !== 32'hAAAA0000) begin n_bad++; $display("FAIL coll_cpu_write: got we=%b addr=%0d data=%h want 1/3/aaaa0000", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    step(0, 0, 32'h0, 32'h0, 1, 1, 6'd3, 32'h0000BBBB);
    n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd3 || bus.mem_wdata !== 32'h0000BBBB) begin n_bad++; $display("FAIL coll_ext_write: got we=%b addr=%0d data=%h want 1/3/0000bbbb", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    idle();
    n_cmp++; if (bus.ext_ack !== 1'b1) begin n_bad++; $display("FAIL coll_ext_ack: got %b want 1", bus.ext_ack); end
    step(1, 0, 32'h0C, 32'h0, 0, 0, 6'd0, 32'h0);
    idle();
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h0000BBBB) begin n_bad++; $display("FAIL coll_readback: got v=%b data=%h want 1/0000bbbb", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  task automatic test_reset_mid();
    idle();
    step(0, 0, 32'h0, 32'h0, 1, 1, 6'd7, 32'h5555AAAA);
    n_cmp++; if (bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL mid_grant_we: got %b want 1", bus.mem_we); end
    for (int i = 0; i < 2; i++) begin
      do_reset();
      n_cmp++; if (bus.ext_ack !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ack[%0d]: got %b want 0", i, bus.ext_ack); end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL mid_reset_we[%0d]: got %b want 0", i, bus.mem_we); end
    end
    // Build up losses, then reset: the count must start over afterwards.
    for (int i = 0; i < 3; i++) step(1, 0, 32'h40, 32'h0, 1, 0, 6'd1, 32'h0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 32'h40, 32'h0, 1, 0, 6'd1, 32'h0);
      n_cmp++; if (bus.cpu_stall !== (i == 4)) begin n_bad++; $display("FAIL mid_after_stall[%0d]: got %b want %b", i, bus.cpu_stall, i == 4); end
      n_cmp++; if (bus.ext_ack !== exp_ack) begin n_bad++; $display("FAIL mid_after_ack[%0d]: got %b want %b", i, bus.ext_ack, exp_ack); end
    end
    idle();
    idle();
  endtask

  task automatic test_load_stall();
    int rv_cnt = 0;
    idle();
    step(1, 1, 32'h50, 32'hC0FFEE00, 0, 0, 6'd0, 32'h0);
    idle();
    for (int i = 0; i < 4; i++)
      step(1, 1, 32'($urandom_range(0, 15)) << 2, $urandom, 1, 1, 6'($urandom_range(0, 15)), $urandom);
    step(1, 0, 32'h50, 32'h0, 1, 1, 6'd2, 32'h1);
    n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_bad++; $display("FAIL ldst_forced_stall: got %b want 1", bus.cpu_stall); end
    step(1, 0, 32'h50, 32'h0, 0, 0, 6'd0, 32'h0);
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL ldst_regrant: got %b want 0", bus.cpu_stall); end
    if (bus.cpu_rvalid === 1'b1) rv_cnt++;
    idle();
    if (bus.cpu_rvalid === 1'b1) rv_cnt++;
    n_cmp++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hC0FFEE00) begin n_bad++; $display("FAIL ldst_data: got v=%b data=%h want 1/c0ffee00", bus.cpu_rvalid, bus.cpu_rdata); end
    idle();
    if (bus.cpu_rvalid === 1'b1) rv_cnt++;
    n_cmp++; if (rv_cnt !== 1) begin n_bad++; $display("FAIL ldst_rvalid_count: got %0d want 1", rv_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom);
      n_cmp++; if (bus.cpu_stall !== exp_stall) begin n_bad++; $display("FAIL rand_stall[%0d]: got %b want %b", i, bus.cpu_stall, exp_stall); end
      n_cmp++; if (bus.mem_we !== exp_we || bus.mem_addr !== exp_addr) begin n_bad++; $display("FAIL rand_mem[%0d]: got we=%b addr=%0d want we=%b addr=%0d", i, bus.mem_we, bus.mem_addr, exp_we, exp_addr); end
      if (exp_we) begin
        n_cmp++; if (bus.mem_wdata !== exp_wd) begin n_bad++; $display("FAIL rand_wdata[%0d]: got %h want %h", i, bus.mem_wdata, exp_wd); end
      end
      n_cmp++; if (bus.ext_ack !== exp_ack || bus.cpu_rvalid !== exp_rvalid) begin n_bad++; $display("FAIL rand_completion[%0d]: got ack=%b rv=%b want ack=%b rv=%b", i, bus.ext_ack, bus.cpu_rvalid, exp_ack, exp_rvalid); end
      if (exp_rvalid) begin
        n_cmp++; if (bus.cpu_rdata !== exp_rdata) begin n_bad++; $display("FAIL rand_cpu_rdata[%0d]: got %h want %h", i, bus.cpu_rdata, exp_rdata); end
      end
      if (ext_hold_known) begin
        n_cmp++; if (bus.ext_rdata !== ext_hold) begin n_bad++; $display("FAIL rand_ext_rdata[%0d]: got %h want %h", i, bus.ext_rdata, ext_hold); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      phys[i]    = '0;
      ref_mem[i] = '0;
    end
    cyc = 0;
    model_reset();
    test_reset();
    test_ext_read();
    test_contention();
    test_collision();
    test_reset_mid();
    test_load_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
